// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants for the fetch prefetch queue
package fetch_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_INSTR_W  = 16;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_PC_STEP  = 2;
  localparam int DEF_RESET_PC = 0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_SQUASH = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  function automatic int entry_w(input int instr_w, input int addr_w);
    return instr_w + addr_w;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH x WIDTH synchronous FIFO with flush
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Flush wins over both ports; a pop frees the slot a same-cycle push fills.
  always_comb begin
    do_pop  = pop && !empty && !flush;
    do_push = push && (!full || do_pop) && !flush;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - fetch FSM, PC register and prefetch FIFO
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PC_STEP  = DEF_PC_STEP,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  input  logic               deq,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_inc,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_stall,
  input  logic               mem_done,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               mem_err,
  output logic               err
);

  localparam int EW    = entry_w(INSTR_W, ADDR_W);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] addr_q;
  logic [EW-1:0]     head;
  logic [CNT_W-1:0]  count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              issue;
  logic              flush;
  logic              push;

  // Issue only with a free slot already present, so the response can always be pushed.
  assign issue = rst_n && (state == ST_IDLE) && (count < CNT_W'(DEPTH))
                 && !halt && !redirect && !mem_stall;
  assign flush = redirect && (state != ST_ERR);
  assign push  = (state == ST_WAIT) && mem_done && !mem_err && !redirect && !fifo_full;

  assign mem_rd     = issue;
  assign mem_addr   = (state == ST_IDLE) ? fetch_pc : addr_q;
  assign err        = (state == ST_ERR);
  assign out_valid  = !fifo_empty;
  assign out_instr  = head[EW-1 -: INSTR_W];
  assign out_pc     = head[ADDR_W-1:0];
  assign out_pc_inc = out_pc + ADDR_W'(PC_STEP);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data ({mem_data, addr_q}),
    .pop       (deq),
    .head_data (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fetch_pc <= ADDR_W'(RESET_PC);
      addr_q   <= ADDR_W'(RESET_PC);
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end else if (issue) begin
            addr_q <= fetch_pc;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            state    <= mem_done ? ST_IDLE : ST_SQUASH;
          end else if (mem_done) begin
            if (mem_err) begin
              state <= ST_ERR;
            end else begin
              fetch_pc <= addr_q + ADDR_W'(PC_STEP);
              state    <= ST_IDLE;
            end
          end
        end
        // The squashed response may coincide with a further redirect; both are honoured.
        ST_SQUASH: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (mem_done) state <= ST_IDLE;
        end
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;

  localparam logic [15:0] DX = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        deq = 1'b0;
  logic        out_valid;
  logic [15:0] out_instr, out_pc, out_pc_inc;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_stall = 1'b0;
  logic        mem_done;
  logic [15:0] mem_data;
  logic        mem_err;
  logic        err;

  int total = 0;
  int bad = 0;
  int lat = 2;
  logic err_inj = 1'b0;

  logic        pend;
  logic [15:0] pend_addr;
  int          pend_cnt;
  logic [15:0] reqs[$];
  logic [15:0] pops[$];

  always #5 clk = ~clk;

  fetch_prefetch_queue #(
    .ADDR_W(16), .INSTR_W(16), .DEPTH(4), .PC_STEP(2), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .deq(deq), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_inc(out_pc_inc), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_data(mem_data),
    .mem_err(mem_err), .err(err)
  );

  // Memory model: fixed latency, data = address ^ DX
  always @(posedge clk) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_cnt <= 0;
    end else if (mem_rd) begin
      pend      <= 1'b1;
      pend_addr <= mem_addr;
      pend_cnt  <= lat - 1;
    end else if (pend && pend_cnt == 0) begin
      pend <= 1'b0;
    end else if (pend) begin
      pend_cnt <= pend_cnt - 1;
    end
  end

  assign mem_done = pend && (pend_cnt == 0);
  assign mem_data = pend_addr ^ DX;
  assign mem_err  = mem_done && err_inj;

  always begin
    @(negedge clk);
    #3;
    if (rst_n && mem_rd) reqs.push_back(mem_addr);
    if (rst_n && deq && out_valid && !redirect) pops.push_back(out_pc);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; halt = 1'b0; deq = 1'b0; err_inj = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reqs.delete();
    pops.delete();
  endtask

  typedef struct {
    logic        deq;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit          seen;
    bit          stale;
    logic [15:0] a;

    vecs[0] = '{1'b0, 1'b1, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 16'h0002};
    vecs[3] = '{1'b0, 1'b1, 16'h0004};
    vecs[4] = '{1'b1, 1'b1, 16'h0004};
    vecs[5] = '{1'b1, 1'b1, 16'h0006};
    vecs[6] = '{1'b1, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 1'b0, 16'h0000};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_err", 32'(err), 32'd0);

    // Fill to DEPTH with 2-cycle memory, no decode
    lat = 2;
    do_reset();
    repeat (30) @(negedge clk);
    #1;
    chk("fill_req_count", reqs.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < reqs.size()) chk("fill_req_addr", 32'(reqs[i]), 32'(2 * i));
    chk("full_no_rd", 32'(mem_rd), 32'd0);
    chk("full_out_pc", 32'(out_pc), 32'h0000);
    chk("full_out_pc_inc", 32'(out_pc_inc), 32'h0002);
    chk("full_out_instr", 32'(out_instr), 32'(16'h0000 ^ DX));

    // Drain under halt from the vector table
    halt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      deq = vecs[i].deq;
      #1;
      chk("tbl_valid", 32'(out_valid), 32'(vecs[i].exp_valid));
      chk("tbl_halt_no_rd", 32'(mem_rd), 32'd0);
      if (vecs[i].exp_valid) begin
        chk("tbl_pc", 32'(out_pc), 32'(vecs[i].exp_pc));
        chk("tbl_pc_inc", 32'(out_pc_inc), 32'(vecs[i].exp_pc + 16'd2));
        chk("tbl_instr", 32'(out_instr), 32'(vecs[i].exp_pc ^ DX));
      end
    end
    chk("halt_req_count", reqs.size(), 32'd4);

    // Halt release resumes at fetch_pc, then streaming with deq held
    @(negedge clk);
    halt = 1'b0;
    lat = 1;
    deq = 1'b1;
    pops.delete();
    #1;
    chk("resume_rd", 32'(mem_rd), 32'd1);
    chk("resume_addr", 32'(mem_addr), 32'h0008);
    repeat (40) @(negedge clk);
    deq = 1'b0;
    chk("stream_pops", 32'(pops.size() >= 10), 32'd1);
    if (pops.size() > 0) chk("stream_first", 32'(pops[0]), 32'h0008);
    for (int i = 1; i < pops.size(); i++)
      chk("stream_step", 32'(pops[i]), 32'(pops[i-1] + 16'd2));

    // Redirect while waiting for 0x0006: response squashed
    lat = 4;
    do_reset();
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (mem_rd && mem_addr == 16'h0006) seen = 1;
    end
    chk("sq_saw_req6", 32'(seen), 32'd1);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("sq_flushed", 32'(out_valid), 32'd0);
    seen = 0; stale = 0; a = '0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) stale = 1;
      if (mem_rd) begin seen = 1; a = mem_addr; end
    end
    chk("sq_new_req", 32'(seen), 32'd1);
    chk("sq_new_addr", 32'(a), 32'h0100);
    chk("sq_no_stale", 32'(stale), 32'd0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("sq_out_pc", 32'(out_pc), 32'h0100);
    chk("sq_out_instr", 32'(out_instr), 32'(16'h0100 ^ DX));

    // Redirect coincident with mem_done and deq
    lat = 2;
    do_reset();
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (mem_done && out_valid) begin
        seen = 1;
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        deq = 1'b1;
      end
    end
    chk("rd_same_seen", 32'(seen), 32'd1);
    @(negedge clk);
    redirect = 1'b0;
    deq = 1'b0;
    #1;
    chk("rd_same_empty", 32'(out_valid), 32'd0);
    chk("rd_same_rd", 32'(mem_rd), 32'd1);
    chk("rd_same_addr", 32'(mem_addr), 32'h0200);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("rd_same_head", 32'(out_pc), 32'h0200);

    // Stall held in IDLE, then released
    mem_stall = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("stall_no_rd", 32'(mem_rd), 32'd0);
    end
    @(negedge clk);
    mem_stall = 1'b0;
    #1;
    chk("stall_drop_rd", 32'(mem_rd), 32'd1);
    chk("stall_drop_addr", 32'(mem_addr), 32'h0000);

    // PC wrap at 0xFFFE
    mem_stall = 1'b1;
    lat = 1;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect = 1'b0;
    mem_stall = 1'b0;
    reqs.delete();
    repeat (8) @(negedge clk);
    chk("wrap_reqs", 32'(reqs.size() >= 2), 32'd1);
    if (reqs.size() >= 2) begin
      chk("wrap_req0", 32'(reqs[0]), 32'hFFFE);
      chk("wrap_req1", 32'(reqs[1]), 32'h0000);
    end
    #1;
    chk("wrap_out_pc", 32'(out_pc), 32'hFFFE);
    chk("wrap_out_pc_inc", 32'(out_pc_inc), 32'h0000);

    // Error: sticky, no push, redirect ignored, cleared by reset
    lat = 2;
    do_reset();
    err_inj = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (mem_done) seen = 1;
    end
    chk("err_done_seen", 32'(seen), 32'd1);
    chk("err_before", 32'(err), 32'd0);
    @(negedge clk);
    #1;
    chk("err_set", 32'(err), 32'd1);
    chk("err_no_push", 32'(out_valid), 32'd0);
    reqs.delete();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("err_no_rd", reqs.size(), 32'd0);
    chk("err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    err_inj = 1'b0;
    @(negedge clk);
    #1;
    chk("err_cleared", 32'(err), 32'd0);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
